// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: memory op codes (also decoded by
// the control unit), FSM state encoding and op classification helpers.
package load_store_unit_pkg;

  localparam logic [5:0] OP_LB  = 6'b010011;
  localparam logic [5:0] OP_LH  = 6'b010100;
  localparam logic [5:0] OP_LW  = 6'b010101;
  localparam logic [5:0] OP_LBU = 6'b010110;
  localparam logic [5:0] OP_LHU = 6'b010111;
  localparam logic [5:0] OP_SB  = 6'b011000;
  localparam logic [5:0] OP_SH  = 6'b011001;
  localparam logic [5:0] OP_SW  = 6'b011010;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } lsu_state_e;

  function automatic logic op_is_load(input logic [5:0] op);
    return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
           (op == OP_LBU) || (op == OP_LHU);
  endfunction

  function automatic logic op_is_store(input logic [5:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic op_is_legal(input logic [5:0] op);
    return op_is_load(op) || op_is_store(op);
  endfunction

  // Byte accesses can never fault; halfwords need bit 0 clear, words both bits.
  function automatic logic op_misaligned(input logic [5:0] op, input logic [1:0] lsb);
    logic fault;
    fault = 1'b0;
    case (op)
      OP_LH, OP_LHU, OP_SH: fault = lsb[0];
      OP_LW, OP_SW:         fault = (lsb != 2'b00);
      default:              fault = 1'b0;
    endcase
    return fault;
  endfunction

endpackage

// File: rtl/load_store_unit_load_align.sv
// Selects the addressed byte/halfword lane of a read word and extends it
// according to the load flavour.
module load_align
  import load_store_unit_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_lsb_i,
  input  logic [5:0]  op_i,
  output logic [31:0] load_data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_i[7:0];
    case (addr_lsb_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = addr_lsb_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    load_data_o = rdata_i;
    case (op_i)
      OP_LB:   load_data_o = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  load_data_o = {24'd0, byte_sel};
      OP_LH:   load_data_o = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  load_data_o = {16'd0, half_sel};
      default: load_data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one outstanding memory access per start, with alignment
// checking, store lane placement, load extraction and a single done pulse.
module load_store_unit
  import load_store_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [5:0]  mem_op,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic [4:0]  rd_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] load_data,
  output logic [4:0]  rd_out,
  output logic        wb_en,
  output logic        misaligned,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  lsu_state_e  state_q;
  logic [5:0]  op_q;
  logic [1:0]  addr_lsb_q;
  logic [4:0]  rd_q;
  logic        busy_q, done_q, wb_en_q, misaligned_q;
  logic        mem_req_q, mem_we_q;
  logic [31:0] mem_addr_q, mem_wdata_q, load_data_q;
  logic [3:0]  mem_be_q;

  logic        start_legal, start_fault;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic [31:0] aligned_data;

  load_align u_load_align (
    .rdata_i     (mem_rdata),
    .addr_lsb_i  (addr_lsb_q),
    .op_i        (op_q),
    .load_data_o (aligned_data)
  );

  assign start_legal = op_is_legal(mem_op);
  assign start_fault = op_misaligned(mem_op, addr[1:0]);

  always_comb begin
    be_d    = '0;
    wdata_d = '0;
    case (mem_op)
      OP_SB: begin
        be_d    = 4'b0001 << addr[1:0];
        wdata_d = {4{store_data[7:0]}};
      end
      OP_SH: begin
        be_d    = 4'b0011 << addr[1:0];
        wdata_d = {2{store_data[15:0]}};
      end
      OP_SW: begin
        be_d    = '1;
        wdata_d = store_data;
      end
      default: begin
        be_d    = '0;
        wdata_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      op_q         <= '0;
      addr_lsb_q   <= '0;
      rd_q         <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      wb_en_q      <= 1'b0;
      misaligned_q <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_be_q     <= '0;
      load_data_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            op_q       <= mem_op;
            addr_lsb_q <= addr[1:0];
            rd_q       <= rd_in;
            busy_q     <= 1'b1;
            if (!start_legal || start_fault) begin
              // Faults and illegal ops complete without touching the bus.
              state_q      <= S_DONE;
              done_q       <= 1'b1;
              misaligned_q <= start_legal;
            end else begin
              state_q     <= S_REQ;
              mem_req_q   <= 1'b1;
              mem_we_q    <= op_is_store(mem_op);
              mem_addr_q  <= {addr[31:2], 2'b00};
              mem_be_q    <= be_d;
              mem_wdata_q <= wdata_d;
            end
          end
        end
        S_REQ: begin
          if (mem_gnt) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            mem_be_q  <= '0;
            if (op_is_store(op_q)) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (mem_rvalid) begin
            load_data_q <= aligned_data;
            wb_en_q     <= (rd_q != '0);
            done_q      <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        S_DONE: begin
          done_q       <= 1'b0;
          wb_en_q      <= 1'b0;
          misaligned_q <= 1'b0;
          busy_q       <= 1'b0;
          state_q      <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign wb_en      = wb_en_q;
  assign misaligned = misaligned_q;
  assign load_data  = load_data_q;
  assign rd_out     = rd_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_be     = mem_be_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: expected completions are queued when a
// request is issued and checked when the done pulse appears.
module tb_load_store_unit;

  localparam logic [5:0] C_LB  = 6'b010011;
  localparam logic [5:0] C_LH  = 6'b010100;
  localparam logic [5:0] C_LW  = 6'b010101;
  localparam logic [5:0] C_LBU = 6'b010110;
  localparam logic [5:0] C_LHU = 6'b010111;
  localparam logic [5:0] C_SB  = 6'b011000;
  localparam logic [5:0] C_SH  = 6'b011001;
  localparam logic [5:0] C_SW  = 6'b011010;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [5:0]  mem_op = '0;
  logic [31:0] addr = '0;
  logic [31:0] store_data = '0;
  logic [4:0]  rd_in = '0;
  logic        busy, done, wb_en, misaligned, mem_req, mem_we;
  logic [31:0] load_data, mem_addr, mem_wdata;
  logic [4:0]  rd_out;
  logic [3:0]  mem_be;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;

  int compared = 0;
  int mismatched = 0;
  int lat_cnt = 0;

  typedef struct {
    string       tag;
    logic [31:0] data;
    logic        chk_data;
    logic [4:0]  rd;
    logic        wb;
    logic        mis;
    int          lat;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .mem_op     (mem_op),
    .addr       (addr),
    .store_data (store_data),
    .rd_in      (rd_in),
    .busy       (busy),
    .done       (done),
    .load_data  (load_data),
    .rd_out     (rd_out),
    .wb_en      (wb_en),
    .misaligned (misaligned),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_be     (mem_be),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    lat_cnt++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drive a one-cycle start, then scramble the inputs to prove they were latched.
  task automatic issue(input string tag, input logic [5:0] op, input logic [31:0] a,
                       input logic [31:0] sd, input logic [4:0] rd, input bit push,
                       input logic [31:0] exp_data, input logic chk_data,
                       input logic exp_wb, input logic exp_mis, input int exp_lat);
    exp_t e;
    start = 1'b1; mem_op = op; addr = a; store_data = sd; rd_in = rd;
    tick();
    lat_cnt = 0;
    start = 1'b0; mem_op = 6'h00; addr = ~a; store_data = ~sd; rd_in = ~rd;
    if (push) begin
      e.tag = tag; e.data = exp_data; e.chk_data = chk_data; e.rd = rd;
      e.wb = exp_wb; e.mis = exp_mis; e.lat = exp_lat;
      sb.push_back(e);
    end
  endtask

  // Hold off the grant for gdelay cycles while checking the request stays put.
  task automatic serve(input string tag, input int gdelay, input bit is_load,
                       input logic [31:0] rdata, input logic [31:0] e_addr,
                       input logic e_we, input logic [3:0] e_be, input logic [31:0] e_wdata);
    for (int k = 0; k <= gdelay; k++) begin
      check({tag, "_req"},   32'(mem_req), 32'd1);
      check({tag, "_addr"},  mem_addr, e_addr);
      check({tag, "_we"},    32'(mem_we), 32'(e_we));
      check({tag, "_be"},    32'(mem_be), 32'(e_be));
      if (e_we) check({tag, "_wdata"}, mem_wdata, e_wdata);
      if (k == gdelay) mem_gnt = 1'b1;
      tick();
    end
    mem_gnt = 1'b0;
    if (is_load) begin
      check({tag, "_req_drop"}, 32'(mem_req), 32'd0);
      mem_rvalid = 1'b1; mem_rdata = rdata;
      tick();
      mem_rvalid = 1'b0; mem_rdata = 32'hDEAD_0000;
    end
  endtask

  task automatic finish_op();
    exp_t e;
    int guard;
    guard = 0;
    while (done !== 1'b1 && guard < 20) begin
      tick();
      guard++;
    end
    if (sb.size() == 0) begin
      compared++;
      mismatched++;
      $error("FAIL scoreboard: observed empty queue expected entry");
      return;
    end
    e = sb.pop_front();
    check({e.tag, "_done"}, 32'(done), 32'd1);
    check({e.tag, "_lat"},  32'(lat_cnt), 32'(e.lat));
    if (e.chk_data) check({e.tag, "_data"}, load_data, e.data);
    check({e.tag, "_rd"},   32'(rd_out), 32'(e.rd));
    check({e.tag, "_wb"},   32'(wb_en), 32'(e.wb));
    check({e.tag, "_mis"},  32'(misaligned), 32'(e.mis));
    tick();
    check({e.tag, "_done_1cyc"}, 32'(done), 32'd0);
    check({e.tag, "_idle"},      32'(busy), 32'd0);
  endtask

  initial begin
    tick(); tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_wb", 32'(wb_en), 32'd0);
    check("rst_mis", 32'(misaligned), 32'd0);
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_be", 32'(mem_be), 32'd0);
    check("rst_ld", load_data, 32'd0);
    check("rst_rd", 32'(rd_out), 32'd0);
    check("rst_maddr", mem_addr, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    reset = 1'b0;
    tick();

    // LB sign-extension from the top lane, gnt at N+1, rvalid at N+2
    issue("lb", C_LB, 32'h0000_1003, 32'h0, 5'd5, 1, 32'hFFFF_FF80, 1, 1, 0, 2);
    serve("lb", 0, 1, 32'h8011_2233, 32'h0000_1000, 0, 4'b0000, 32'h0);
    finish_op();

    // SH into the upper half
    issue("sh", C_SH, 32'h0000_2002, 32'h0000_BEEF, 5'd7, 1, 32'h0, 0, 0, 0, 1);
    serve("sh", 0, 0, 32'h0, 32'h0000_2000, 1, 4'b1100, 32'hBEEF_BEEF);
    finish_op();

    // Misaligned LW completes immediately without a request
    issue("lw_mis", C_LW, 32'h0000_3001, 32'h0, 5'd4, 1, 32'h0, 0, 0, 1, 0);
    check("lw_mis_noreq", 32'(mem_req), 32'd0);
    finish_op();
    check("lw_mis_noreq_after", 32'(mem_req), 32'd0);

    // LHU with grant held off three cycles
    issue("lhu", C_LHU, 32'h0000_4002, 32'h0, 5'd9, 1, 32'h0000_A5A5, 1, 1, 0, 5);
    serve("lhu", 3, 1, 32'hA5A5_1234, 32'h0000_4000, 0, 4'b0000, 32'h0);
    finish_op();

    // Reset while waiting for read data aborts the access
    issue("abort", C_LW, 32'h0000_5000, 32'h0, 5'd3, 0, 32'h0, 0, 0, 0, 0);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    check("abort_in_wait", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_req", 32'(mem_req), 32'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222;
    tick();
    mem_rvalid = 1'b0;
    check("abort_done", 32'(done), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_req2", 32'(mem_req), 32'd0);
    tick();
    check("abort_done2", 32'(done), 32'd0);

    // start while busy is ignored; the SW request must not be disturbed
    issue("sw_busy", C_SW, 32'h0000_6000, 32'hDEAD_BEEF, 5'd0, 1, 32'h0, 0, 0, 0, 3);
    start = 1'b1; mem_op = C_LB; addr = 32'h0000_6101; rd_in = 5'd9;
    tick();
    start = 1'b0;
    serve("sw_busy", 1, 0, 32'h0, 32'h0000_6000, 1, 4'b1111, 32'hDEAD_BEEF);
    finish_op();

    // Illegal op 0x3F: done next cycle, no fault, no write-back, no bus
    issue("illegal", 6'h3F, 32'h0000_6004, 32'h0, 5'd12, 1, 32'h0, 0, 0, 0, 0);
    check("illegal_noreq", 32'(mem_req), 32'd0);
    finish_op();

    issue("sb", C_SB, 32'h0000_7001, 32'h1234_56AB, 5'd1, 1, 32'h0, 0, 0, 0, 1);
    serve("sb", 0, 0, 32'h0, 32'h0000_7000, 1, 4'b0010, 32'hABAB_ABAB);
    finish_op();

    issue("lh", C_LH, 32'h0000_8002, 32'h0, 5'd31, 1, 32'hFFFF_8001, 1, 1, 0, 2);
    serve("lh", 0, 1, 32'h8001_7FFF, 32'h0000_8000, 0, 4'b0000, 32'h0);
    finish_op();

    issue("lbu", C_LBU, 32'h0000_9002, 32'h0, 5'd2, 1, 32'h0000_00C3, 1, 1, 0, 2);
    serve("lbu", 0, 1, 32'h00C3_0000, 32'h0000_9000, 0, 4'b0000, 32'h0);
    finish_op();

    issue("lh_mis", C_LH, 32'h0000_8001, 32'h0, 5'd6, 1, 32'h0, 0, 0, 1, 0);
    finish_op();

    // Load to x0 never writes back
    issue("lb_x0", C_LB, 32'h0000_B000, 32'h0, 5'd0, 1, 32'h0000_007F, 1, 0, 0, 2);
    serve("lb_x0", 0, 1, 32'hFFFF_FF7F, 32'h0000_B000, 0, 4'b0000, 32'h0);
    finish_op();

    issue("sw", C_SW, 32'h0000_A004, 32'h0102_0304, 5'd8, 1, 32'h0, 0, 0, 0, 1);
    serve("sw", 0, 0, 32'h0, 32'h0000_A004, 1, 4'b1111, 32'h0102_0304);
    finish_op();

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have ports (name  direction  width  meaning):
- clk  in  1  rising-edge clock
- reset  in  1  reset, synchronous, active-high
- start  in  1  one-cycle request from execute stage
- mem_op  in  6  decoded op code from control unit
- addr  in  32  effective byte address (base+imm from ALU)
- store_data  in  32  rs2 value
- rd_in  in  5  destination register
- busy  out  1  operation in progress; upstream stalls
- done  out  1  one-cycle completion pulse
- load_data  out  32  extended load result, valid with done
- rd_out  out  5  latched rd_in, valid with done
- wb_en  out  1  register write enable, valid with done
- misaligned  out  1  alignment fault, valid with done
- mem_req  out  1  bus request
- mem_we  out  1  1=write
- mem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- mem_wdata  out  32  lane-positioned store data
- mem_be  out  4  byte enables
- mem_gnt  in  1  request accepted this cycle
- mem_rvalid  in  1  read data valid
- mem_rdata  in  32  read word

Function
REQ-002 SHALL decode mem_op: 010011 LB, 010100 LH, 010101 LW, 010110 LBU, 010111 LHU, 011000 SB, 011001 SH, 011010 SW; any other code is illegal.
REQ-003 SHALL use FSM states IDLE, REQ, WAIT, DONE.
REQ-004 SHALL accept start only in IDLE; start while busy is ignored.
REQ-005 SHALL latch mem_op, addr, store_data, rd_in on the accepting edge.
REQ-006 IDLE->REQ on legal, aligned start; IDLE->DONE on illegal op or misaligned address.
REQ-007 Misaligned: halfword with addr[0]=1, word with addr[1:0]!=0; byte never misaligned.
REQ-008 REQ: mem_req=1, with mem_addr/mem_we/mem_wdata/mem_be held stable until mem_gnt sampled high.
REQ-009 REQ->DONE on mem_gnt for stores; REQ->WAIT on mem_gnt for loads.
REQ-010 WAIT->DONE on mem_rvalid; SHALL capture mem_rdata that cycle.
REQ-011 DONE: done=1 for exactly one cycle, then IDLE; a new start is accepted in the following IDLE cycle.
REQ-012 busy=1 in REQ, WAIT, DONE; 0 in IDLE.
REQ-013 Byte enables: SB 4'b0001<<addr[1:0]; SH 4'b0011<<addr[1:0]; SW 4'b1111; loads 4'b0000 with mem_we=0.
REQ-014 Store data: SB replicates byte[7:0] to all lanes; SH replicates [15:0] to both halves; SW passes through.
REQ-015 Load extraction: byte lane addr[1:0], halfword lane addr[1]; LB/LH sign-extend, LBU/LHU zero-extend, LW unmodified.
REQ-016 wb_en=1 with done only for successful loads with rd_out!=0; 0 for stores, faults, illegal ops.
REQ-017 misaligned=1 with done only for REQ-007 faults; no memory request issued.
REQ-018 Illegal op: done at N+1 with wb_en=0, misaligned=0, no bus activity.
REQ-019 Latency from accepting edge N: mem_req at N+1; zero-wait store done at N+2; load with gnt at N+1 and rvalid at N+2 done at N+3.
REQ-020 mem_gnt in WAIT and mem_rvalid outside WAIT SHALL be ignored.

Reset
REQ-021 On reset: state IDLE; busy, done, wb_en, misaligned, mem_req, mem_we = 0; mem_be = 0; load_data, rd_out, mem_addr, mem_wdata = 0.
REQ-022 Reset during REQ/WAIT SHALL abort: mem_req low from the next edge, no done pulse, late mem_rvalid discarded.

Structure
REQ-023 Shared package SHALL hold mem_op code constants (shared with control unit) and FSM state encoding.
REQ-024 One combinational sub-module load_align (rdata, addr[1:0], op -> load_data) is natural; store lane logic stays inline.

Verification
REQ-025 LB addr=0x1003, rdata=0x80112233 -> load_data=0xFFFFFF80, wb_en=1, done at N+3 with gnt at N+1, rvalid at N+2.
REQ-026 SH addr=0x2002, store_data=0x0000BEEF -> mem_addr=0x2000, mem_be=4'b1100, mem_wdata=0xBEEFBEEF, mem_we=1.
REQ-027 LW addr=0x3001 -> done+misaligned at N+1, mem_req never asserted, wb_en=0.
REQ-028 LHU addr=0x4002, gnt delayed 3 cycles, rdata=0xA5A51234 -> request held stable while gnt low; load_data=0x0000A5A5.
REQ-029 Reset asserted in WAIT, then rvalid -> no done pulse, busy=0, mem_req=0.
REQ-030 start pulsed while busy; op code 0x3F -> first ignored; illegal op gives done at N+1 with wb_en=0.
